// File: rtl/ps2_pkg.sv
// Shared constants, frame FSM state type and no-event byte test for the PS/2 key decoder.
package ps2_pkg;

   localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
   localparam logic [7:0] PS2_PFX_REL   = 8'hF0;
   localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;
   localparam logic [7:0] PAUSE_CODE    = 8'h77;
   localparam int         PAUSE_SKIP    = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2
   } frame_state_t;

   // Keyboard status/ack bytes that never map to a key event.
   function automatic logic is_no_event(input logic [7:0] b);
      return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
   endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Bundles the raw PS/2 line pair and the decoded key-event outputs.
interface ps2_key_decoder_if;
   logic        ps2_clk_i;
   logic        ps2_data_i;
   logic [10:0] ps2_key;
   logic        key_strobe;
   logic        frame_err;

   modport master (
      output ps2_clk_i, ps2_data_i,
      input  ps2_key, key_strobe, frame_err
   );

   modport slave (
      input  ps2_clk_i, ps2_data_i,
      output ps2_key, key_strobe, frame_err
   );
endinterface

// File: rtl/ps2_key_decoder_frame_rx.sv
// PS/2 frame receiver: sync + glitch filter, 11-bit frame shifter, parity/stop check, bit watchdog.
module ps2_frame_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 48000
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_data,
   output logic       o_byte_valid,
   output logic [7:0] o_byte,
   output logic       o_frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int WW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
   localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT_CYC - 1);

   logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
   logic          r_clk_filt;
   logic [FW-1:0] r_filt_cnt;
   logic [WW-1:0] r_wd_cnt;
   logic [3:0]    r_bit_cnt;
   logic [9:0]    r_shift;
   frame_state_t  r_state, w_state_nxt;

   logic w_clk_diff, w_clk_flip, w_fall, w_wd_expired, w_frame_ok;

   assign w_clk_diff   = (r_clk_s2 != r_clk_filt);
   assign w_clk_flip   = w_clk_diff && (r_filt_cnt == FILT_MAX);
   assign w_fall       = w_clk_flip && !r_clk_s2;
   assign w_wd_expired = (r_wd_cnt == WD_MAX);
   // Shifter holds {stop, parity, d7..d0}; odd parity over data+parity.
   assign w_frame_ok   = r_shift[9] && (^r_shift[8:0]);

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_clk_s1   <= 1'b1;
         r_clk_s2   <= 1'b1;
         r_dat_s1   <= 1'b1;
         r_dat_s2   <= 1'b1;
         r_clk_filt <= 1'b1;
         r_filt_cnt <= '0;
      end else begin
         r_clk_s1 <= i_ps2_clk;
         r_clk_s2 <= r_clk_s1;
         r_dat_s1 <= i_ps2_data;
         r_dat_s2 <= r_dat_s1;
         if (!w_clk_diff) begin
            r_filt_cnt <= '0;
         end else if (w_clk_flip) begin
            r_filt_cnt <= '0;
            r_clk_filt <= r_clk_s2;
         end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_fall && !r_dat_s2) w_state_nxt = SHIFT;
         SHIFT: begin
            if (w_fall) begin
               if (r_bit_cnt == 4'd10) w_state_nxt = CHECK;
            end else if (w_wd_expired) begin
               w_state_nxt = IDLE;
            end
         end
         CHECK:   w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_wd_cnt  <= '0;
      end else begin
         if (r_state == SHIFT && !w_fall) r_wd_cnt <= r_wd_cnt + 1'b1;
         else                             r_wd_cnt <= '0;
         if (r_state == IDLE && w_fall && !r_dat_s2) begin
            r_bit_cnt <= 4'd1;
         end else if (r_state == SHIFT && w_fall) begin
            r_shift   <= {r_dat_s2, r_shift[9:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
         end
      end
   end

   always_comb begin
      o_byte       = r_shift[7:0];
      o_byte_valid = (r_state == CHECK) && w_frame_ok;
      o_frame_err  = ((r_state == CHECK) && !w_frame_ok) ||
                     ((r_state == SHIFT) && !w_fall && w_wd_expired);
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard to 11-bit key-event word {toggle, pressed, extended, code}.
// Handles E0/F0 prefixes, swallows the 8-byte Pause sequence and status bytes.
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 48000
) (
   input  logic              clk_sys,
   input  logic              reset,
   ps2_key_decoder_if.slave  bus
);

   logic        w_byte_valid, w_frame_err;
   logic [7:0]  w_byte;
   logic [10:0] r_key;
   logic        r_strobe, r_ext, r_rel;
   logic [2:0]  r_skip_cnt;

   ps2_frame_rx #(
      .FILTER_LEN  (FILTER_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_rx (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .i_ps2_clk    (bus.ps2_clk_i),
      .i_ps2_data   (bus.ps2_data_i),
      .o_byte_valid (w_byte_valid),
      .o_byte       (w_byte),
      .o_frame_err  (w_frame_err)
   );

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_key      <= '0;
         r_strobe   <= 1'b0;
         r_ext      <= 1'b0;
         r_rel      <= 1'b0;
         r_skip_cnt <= '0;
      end else begin
         r_strobe <= 1'b0;
         if (w_frame_err) begin
            r_ext <= 1'b0;
            r_rel <= 1'b0;
         end else if (w_byte_valid) begin
            // Pause tail bytes are consumed blindly; the last one emits the key.
            if (r_skip_cnt != 3'd0) begin
               r_skip_cnt <= r_skip_cnt - 3'd1;
               if (r_skip_cnt == 3'd1) begin
                  r_key    <= {~r_key[10], 1'b1, 1'b1, PAUSE_CODE};
                  r_strobe <= 1'b1;
               end
            end else if (w_byte == PS2_PFX_PAUSE) begin
               r_skip_cnt <= 3'(PAUSE_SKIP);
            end else if (w_byte == PS2_PFX_EXT) begin
               r_ext <= 1'b1;
            end else if (w_byte == PS2_PFX_REL) begin
               r_rel <= 1'b1;
            end else if (is_no_event(w_byte)) begin
               r_ext <= 1'b0;
               r_rel <= 1'b0;
            end else begin
               r_key    <= {~r_key[10], ~r_rel, r_ext, w_byte};
               r_strobe <= 1'b1;
               r_ext    <= 1'b0;
               r_rel    <= 1'b0;
            end
         end
      end
   end

   assign bus.ps2_key    = r_key;
   assign bus.key_strobe = r_strobe;
   assign bus.frame_err  = w_frame_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomized + directed scoreboard bench for ps2_key_decoder against a byte-level event model.
module tb_ps2_key_decoder;
   import ps2_pkg::*;

   localparam int FILT = 8;
   localparam int TMO  = 1000;
   localparam int HALF = 20;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ps2_key_decoder_if bus();

   ps2_key_decoder #(.FILTER_LEN(FILT), .TIMEOUT_CYC(TMO)) dut (
      .clk_sys (clk),
      .reset   (rst),
      .bus     (bus.slave)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [10:0] exp_q[$];
   int          err_pend = 0;

   // Reference model state: one key event per non-prefix byte.
   bit          m_tog, m_ext, m_rel;
   int          m_skip;
   logic [10:0] m_key;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_tog = 0; m_ext = 0; m_rel = 0; m_skip = 0; m_key = '0;
   endtask

   task automatic model_emit(input logic [7:0] code, input bit pressed, input bit ext);
      m_tog = ~m_tog;
      m_key = 11'((int'(m_tog) * 1024) + (int'(pressed) * 512) + (int'(ext) * 256) + int'(code));
      exp_q.push_back(m_key);
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (m_skip > 0) begin
         m_skip--;
         if (m_skip == 0) model_emit(8'h77, 1'b1, 1'b1);
      end else if (b == 8'hE1) begin
         m_skip = 7;
      end else if (b == 8'hE0) begin
         m_ext = 1;
      end else if (b == 8'hF0) begin
         m_rel = 1;
      end else if (b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA ||
                   b == 8'hFC || b == 8'hFE || b == 8'hFF) begin
         m_ext = 0; m_rel = 0;
      end else begin
         model_emit(b, ~m_rel, m_ext);
         m_ext = 0; m_rel = 0;
      end
   endtask

   task automatic model_err();
      err_pend++;
      m_ext = 0; m_rel = 0;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(input logic [7:0] b, input bit bad, input int nbits);
      logic [10:0] fr;
      fr = {1'b1, (~^b) ^ bad, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         bus.ps2_data_i = fr[i];
         wait_cyc(HALF / 2);
         bus.ps2_clk_i = 1'b0;
         wait_cyc(HALF);
         bus.ps2_clk_i = 1'b1;
         wait_cyc(HALF / 2);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad);
      if (bad) model_err();
      else     model_byte(b);
      send_bits(b, bad, 11);
      bus.ps2_data_i = 1'b1;
      wait_cyc(30);
   endtask

   // Monitor: pops expectations whenever the DUT presents an event or error.
   initial begin
      logic [10:0] e;
      forever begin
         @(negedge clk);
         if (bus.key_strobe === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_strobe: got key %0h expected no strobe", bus.ps2_key);
            end else begin
               e = exp_q.pop_front();
               chk("strobe_key", 32'(bus.ps2_key), 32'(e));
            end
         end
         if (bus.frame_err === 1'b1) begin
            n_checks++;
            if (err_pend == 0) begin
               n_fail++;
               $display("FAIL unexpected_frame_err: got 1 expected 0");
            end else begin
               err_pend--;
            end
         end
      end
   end

   initial begin
      logic [7:0] b;
      int         r;
      bit         bad;
      logic [7:0] noev [7];
      noev = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};

      model_reset();
      rst = 1'b1;
      bus.ps2_clk_i  = 1'b1;
      bus.ps2_data_i = 1'b1;
      wait_cyc(5);
      chk("reset_key", 32'(bus.ps2_key), 32'h0);
      chk("reset_strobe", 32'(bus.key_strobe), 32'h0);
      chk("reset_err", 32'(bus.frame_err), 32'h0);
      rst = 1'b0;
      wait_cyc(20);

      // Make / break
      send_frame(8'h1C, 0);
      chk("make_1c", 32'(bus.ps2_key), 32'h61C);
      send_frame(8'hF0, 0);
      send_frame(8'h1C, 0);
      chk("break_1c", 32'(bus.ps2_key), 32'h01C);

      // Extended make / break
      send_frame(8'hE0, 0);
      send_frame(8'h75, 0);
      chk("ext_make_75", 32'(bus.ps2_key), 32'h775);
      send_frame(8'hE0, 0);
      send_frame(8'hF0, 0);
      send_frame(8'h75, 0);
      chk("ext_break_75", 32'(bus.ps2_key), 32'h175);

      // Parity error clears a pending prefix and leaves ps2_key alone
      send_frame(8'hE0, 0);
      send_frame(8'h16, 1);
      chk("parity_err_key_hold", 32'(bus.ps2_key), 32'h175);
      send_frame(8'h16, 0);
      chk("after_parity_16", 32'(bus.ps2_key[9:0]), 32'h216);

      // Watchdog timeout after 5 bits
      send_frame(8'hE0, 0);
      model_err();
      send_bits(8'h29, 0, 5);
      bus.ps2_data_i = 1'b1;
      wait_cyc(TMO + 200);
      chk("timeout_err_seen", 32'(err_pend), 32'h0);
      send_frame(8'h29, 0);
      chk("after_timeout_29", 32'(bus.ps2_key[9:0]), 32'h229);

      // Pause sequence: one event only
      send_frame(8'hE1, 0);
      send_frame(8'h14, 0);
      send_frame(8'h77, 0);
      send_frame(8'hE1, 0);
      send_frame(8'hF0, 0);
      send_frame(8'h14, 0);
      send_frame(8'hF0, 0);
      send_frame(8'h77, 0);
      chk("pause_key", 32'(bus.ps2_key[9:0]), 32'h377);

      // Clock glitch shorter than the filter, with data low so a capture would look like a start bit
      bus.ps2_data_i = 1'b0;
      wait_cyc(5);
      bus.ps2_clk_i = 1'b0;
      wait_cyc(3);
      bus.ps2_clk_i = 1'b1;
      wait_cyc(10);
      bus.ps2_data_i = 1'b1;
      wait_cyc(TMO + 100);
      send_frame(8'h1C, 0);
      chk("after_glitch_1c", 32'(bus.ps2_key), 32'(m_key));

      // Randomized byte stream
      for (int n = 0; n < 30; n++) begin
         r = $urandom_range(0, 9);
         case (r)
            0:       b = 8'hE0;
            1:       b = 8'hF0;
            2:       b = noev[$urandom_range(0, 6)];
            3:       b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h5A;
            default: b = 8'($urandom_range(0, 255));
         endcase
         bad = ($urandom_range(0, 9) == 0);
         send_frame(b, bad);
      end
      chk("random_key", 32'(bus.ps2_key), 32'(m_key));
      chk("random_drained", 32'(exp_q.size()), 32'h0);

      // Reset after 6 bits of a frame
      send_bits(8'h3A, 0, 6);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      bus.ps2_data_i = 1'b1;
      chk("midframe_reset_key", 32'(bus.ps2_key), 32'h0);
      wait_cyc(50);
      send_frame(8'h1C, 0);
      chk("post_reset_1c", 32'(bus.ps2_key), 32'h61C);

      for (int i = 0; i < 2000 && (exp_q.size() != 0 || err_pend != 0); i++) @(negedge clk);
      chk("final_events_drained", 32'(exp_q.size()), 32'h0);
      chk("final_errs_drained", 32'(err_pend), 32'h0);
      chk("final_key", 32'(bus.ps2_key), 32'(m_key));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
